tl_intersection: RTL and testbench
==================================

// Module: tl_intersection
// PURPOSE
//  Behavioural intersection model at the far end of the traffic-light interface.
//  Consumes light codes La/Lb and drives the car sensors Ta/Tb.
//  Keeps a car queue per street, releases cars while that street's light permits,
//  and checks the light sequence for protocol violations.
//  Closes the loop around the controller in system-level simulation and FPGA demos.
// PARAMETERS
//  QW          4  queue counter width; max queue depth = 2**QW-1
//  DEPART_CYC  2  permitted cycles per released car (>=1)
//  YEL_PASS    1  1: cars are also released on YELLOW; 0: GREEN only
// PORTS
//  clk       in   1   rising-edge clock
//  reset     in   1   asynchronous, active-high reset
//  La        in   2   street A light: 00 GREEN, 01 YELLOW, 10 RED, 11 illegal
//  Lb        in   2   street B light, same coding
//  arr_a     in   1   one car arrives on A this cycle
//  arr_b     in   1   one car arrives on B this cycle
//  Ta        out  1   A sensor: car waiting on A (qa != 0)
//  Tb        out  1   B sensor: car waiting on B (qb != 0)
//  qa        out  QW  A queue depth
//  qb        out  QW  B queue depth
//  drop_a    out  1   1-cycle pulse: A arrival lost, queue full
//  drop_b    out  1   1-cycle pulse: B arrival lost, queue full
//  err       out  1   sticky: protocol violation seen
//  err_code  out  3   sticky flags: [0] code 11, [1] illegal transition, [2] conflict
// BEHAVIOUR
//  Reset (asynchronous, active-high): qa=qb=0, Ta=Tb=0, drop_*=0, err=0,
//   err_code=0, departure timers=0, prev-light valid=0.
//  permit_x = (Lx==GREEN) | (YEL_PASS & Lx==YELLOW).
//  Departure timer (per street):
//   - Counts while permit_x; cleared to 0 on any cycle with !permit_x.
//   - dep_x = permit_x & (timer==DEPART_CYC-1) & (qx!=0).
//   - Timer wraps to 0 on reaching DEPART_CYC-1, whether or not a car left.
//  Queue update at each edge:
//   - arr & !dep: +1.
//   - dep & !arr: -1.
//   - arr & dep: unchanged.
//   - Full queue (all ones) & arr & !dep: count holds; drop_x=1 for that cycle.
//   - Empty queue never decrements: dep is already gated by qx!=0.
//  Latency:
//   - Ta/Tb are combinational from the qa/qb registers.
//   - Arrival sampled at edge n is visible on Ta after edge n.
//   - Ta falls after the edge that releases the last car.
//  Protocol checker (registered prev La/Lb; valid set 1 cycle after reset release):
//   - Legal per-street transitions: G->G, G->Y, Y->Y, Y->R, R->R, R->G; all others set [1].
//   - No transition check on the first cycle after reset (prev not valid).
//   - Any La or Lb == 11 sets [0]; no transition check that cycle for that street.
//   - La!=RED & Lb!=RED in the same cycle sets [2].
//   - Flags OR in; err = |err_code. Cleared only by reset.
//   - Errors do not affect queue operation.
//  Reset asserted mid-operation clears queues immediately; arrivals during reset are ignored.
// STRUCTURE
//  tl_defs.vh (shared with tl_cntr): GREEN=2'b00, YELLOW=2'b01, RED=2'b10, ILLEGAL=2'b11.
//  Sub-module tl_lane, instanced twice:
//   - ports clk, reset, L, arr -> q, T, drop;
//   - holds queue counter, departure timer and permit logic;
//   - parameters QW, DEPART_CYC, YEL_PASS.
//  Top holds the prev-light registers and the protocol checker.
// TESTING
//  1. Reset, La=RED, Lb=RED, 3 arr_a pulses -> qa=3, Ta=1, Tb=0, no departures, err=0.
//  2. qa=3, La=GREEN for 6 cycles, DEPART_CYC=2 -> qa steps 3,3,2,2,1,1,0; Ta=0 after last
//     release.
//  3. QW=2, qa=3 (full), La=RED, arr_a=1 -> qa stays 3, drop_a=1 for 1 cycle;
//     same with La=GREEN on a release cycle -> qa=3, no drop.
//  4. La sequence G->R (skipping Y) -> err_code=3'b010, err=1, stays set after La returns legal.
//  5. La=GREEN, Lb=YELLOW same cycle -> err_code[2]=1; La=2'b11 -> err_code[0]=1.
//  6. Reset pulse mid-release with qa=5 -> qa=0, Ta=0, err=0 immediately, before the next
//     clk edge.

Source files
------------

// File: rtl/tl_intersection_pkg.sv
// Shared definitions for the intersection model: light codes and the
// per-street legal-transition rule used by the protocol checker.
package tl_intersection_pkg;

  typedef enum logic [1:0] {
    GREEN   = 2'b00,
    YELLOW  = 2'b01,
    RED     = 2'b10,
    ILLEGAL = 2'b11
  } light_t;

  // Legal per-street steps: G->G, G->Y, Y->Y, Y->R, R->R, R->G.
  // A previous code of ILLEGAL has no legal successor.
  function automatic logic legal_step(input logic [1:0] prev, input logic [1:0] cur);
    logic ok;
    ok = 1'b0;
    case (prev)
      GREEN:   ok = (cur == GREEN)  || (cur == YELLOW);
      YELLOW:  ok = (cur == YELLOW) || (cur == RED);
      RED:     ok = (cur == RED)    || (cur == GREEN);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/tl_intersection_if.sv
// Traffic-light interface between a controller (master) and the
// intersection model (slave).
//   La, Lb     : light codes for streets A and B (master -> slave)
//   arr_a/b    : car arrival strobes (master -> slave)
//   Ta, Tb     : car-waiting sensors (slave -> master)
//   qa, qb     : queue depths (slave -> master)
//   drop_a/b   : arrival-lost pulses (slave -> master)
//   err        : sticky protocol violation (slave -> master)
//   err_code   : sticky flags [0] code 11, [1] illegal step, [2] conflict
interface tl_intersection_if #(
  parameter int unsigned QW = 4
);
  logic [1:0]    La;
  logic [1:0]    Lb;
  logic          arr_a;
  logic          arr_b;
  logic          Ta;
  logic          Tb;
  logic [QW-1:0] qa;
  logic [QW-1:0] qb;
  logic          drop_a;
  logic          drop_b;
  logic          err;
  logic [2:0]    err_code;

  modport master (
    output La, Lb, arr_a, arr_b,
    input  Ta, Tb, qa, qb, drop_a, drop_b, err, err_code
  );

  modport slave (
    input  La, Lb, arr_a, arr_b,
    output Ta, Tb, qa, qb, drop_a, drop_b, err, err_code
  );
endinterface

// File: rtl/tl_intersection_lane.sv
// One street of the intersection: car queue, departure timer, permit logic.
//   clk, reset : clock, asynchronous active-high reset
//   L          : this street's light code
//   arr        : one car arrives this cycle
//   q          : queue depth
//   T          : car waiting (q != 0), combinational from q
//   drop       : registered pulse, arrival lost because the queue was full
module tl_lane
  import tl_intersection_pkg::*;
#(
  parameter int unsigned QW         = 4,
  parameter int unsigned DEPART_CYC = 2,
  parameter int unsigned YEL_PASS   = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    L,
  input  logic          arr,
  output logic [QW-1:0] q,
  output logic          T,
  output logic          drop
);

  localparam int unsigned TW = (DEPART_CYC > 1) ? $clog2(DEPART_CYC) : 1;
  localparam logic [TW-1:0] LAST = TW'(DEPART_CYC - 1);

  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  logic          permit;
  logic          at_last;
  logic          dep;
  logic          full;

  always_comb begin
    permit  = (L == GREEN) || ((YEL_PASS != 0) && (L == YELLOW));
    at_last = (timer == LAST);
    dep     = permit && at_last && (q != '0);
    full    = &q;
    // Timer wraps at LAST regardless of whether a car actually left.
    timer_nxt = '0;
    if (permit && !at_last)
      timer_nxt = timer + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q     <= '0;
      timer <= '0;
      drop  <= 1'b0;
    end else begin
      timer <= timer_nxt;
      drop  <= arr && !dep && full;
      if (arr && !dep && !full)
        q <= q + 1'b1;
      else if (dep && !arr)
        q <= q - 1'b1;
    end
  end

  assign T = (q != '0);

endmodule

// File: rtl/tl_intersection.sv
// Behavioural intersection at the far end of the traffic-light interface.
// Two tl_lane instances hold the street queues; this level registers the
// previous light codes and runs the sticky protocol checker.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : tl_intersection_if slave (lights/arrivals in, sensors/status out)
module tl_intersection
  import tl_intersection_pkg::*;
#(
  parameter int unsigned QW         = 4,
  parameter int unsigned DEPART_CYC = 2,
  parameter int unsigned YEL_PASS   = 1
) (
  input  logic           clk,
  input  logic           reset,
  tl_intersection_if.slave bus
);

  logic [1:0] prev_a;
  logic [1:0] prev_b;
  logic       prev_valid;
  logic [2:0] err_q;
  logic [2:0] flags;

  tl_lane #(.QW(QW), .DEPART_CYC(DEPART_CYC), .YEL_PASS(YEL_PASS)) u_lane_a (
    .clk   (clk),
    .reset (reset),
    .L     (bus.La),
    .arr   (bus.arr_a),
    .q     (bus.qa),
    .T     (bus.Ta),
    .drop  (bus.drop_a)
  );

  tl_lane #(.QW(QW), .DEPART_CYC(DEPART_CYC), .YEL_PASS(YEL_PASS)) u_lane_b (
    .clk   (clk),
    .reset (reset),
    .L     (bus.Lb),
    .arr   (bus.arr_b),
    .q     (bus.qb),
    .T     (bus.Tb),
    .drop  (bus.drop_b)
  );

  // A street showing code 11 is excluded from the transition check that cycle.
  always_comb begin
    flags = '0;
    if ((bus.La == ILLEGAL) || (bus.Lb == ILLEGAL))
      flags[0] = 1'b1;
    if (prev_valid) begin
      if ((bus.La != ILLEGAL) && !legal_step(prev_a, bus.La))
        flags[1] = 1'b1;
      if ((bus.Lb != ILLEGAL) && !legal_step(prev_b, bus.Lb))
        flags[1] = 1'b1;
    end
    if ((bus.La != RED) && (bus.Lb != RED))
      flags[2] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_a     <= RED;
      prev_b     <= RED;
      prev_valid <= 1'b0;
      err_q      <= '0;
    end else begin
      prev_a     <= bus.La;
      prev_b     <= bus.Lb;
      prev_valid <= 1'b1;
      err_q      <= err_q | flags;
    end
  end

  assign bus.err_code = err_q;
  assign bus.err      = |err_q;

endmodule

// File: tb/tb_tl_intersection.sv
module tb_tl_intersection;
  import tl_intersection_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int unsigned npass = 0;
  int unsigned ntotal = 0;

  always #5 clk = ~clk;

  tl_intersection_if #(.QW(4)) b1 ();
  tl_intersection_if #(.QW(2)) b2 ();

  tl_intersection #(.QW(4), .DEPART_CYC(2), .YEL_PASS(1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  tl_intersection #(.QW(2), .DEPART_CYC(2), .YEL_PASS(1)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  int exp_q[6] = '{3, 2, 2, 1, 1, 0};
  int exp_b[4] = '{2, 1, 1, 0};

  initial begin
    reset = 1'b1;
    b1.La = RED; b1.Lb = RED; b1.arr_a = 1'b0; b1.arr_b = 1'b0;
    b2.La = RED; b2.Lb = RED; b2.arr_a = 1'b0; b2.arr_b = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_qa", 32'(b1.qa), 0);
    check("rst_qb", 32'(b1.qb), 0);
    check("rst_Ta", 32'(b1.Ta), 0);
    check("rst_Tb", 32'(b1.Tb), 0);
    check("rst_drop_a", 32'(b1.drop_a), 0);
    check("rst_err", 32'(b1.err), 0);
    check("rst_err_code", 32'(b1.err_code), 0);

    // 1. Three arrivals on red
    b1.arr_a = 1'b1;
    step(); step(); step();
    b1.arr_a = 1'b0;
    check("t1_qa", 32'(b1.qa), 3);
    check("t1_Ta", 32'(b1.Ta), 1);
    check("t1_Tb", 32'(b1.Tb), 0);
    step();
    check("t1_qa_hold", 32'(b1.qa), 3);
    check("t1_err", 32'(b1.err), 0);

    // 2. Green releases one car every two cycles
    b1.La = GREEN;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("t2_qa_%0d", i), 32'(b1.qa), 32'(exp_q[i]));
    end
    check("t2_Ta_low", 32'(b1.Ta), 0);
    b1.La = YELLOW; step();
    b1.La = RED;    step();
    check("t2_err_legal", 32'(b1.err), 0);

    // 3. Full queue on the QW=2 instance
    do_reset();
    b2.arr_a = 1'b1;
    step(); step(); step();
    check("t3_qa_full", 32'(b2.qa), 3);
    check("t3_drop_none", 32'(b2.drop_a), 0);
    step();
    check("t3_qa_hold", 32'(b2.qa), 3);
    check("t3_drop_pulse", 32'(b2.drop_a), 1);
    b2.arr_a = 1'b0;
    step();
    check("t3_drop_end", 32'(b2.drop_a), 0);
    b2.La = GREEN;
    step();
    check("t3_qa_wait", 32'(b2.qa), 3);
    b2.arr_a = 1'b1;
    step();
    check("t3_qa_swap", 32'(b2.qa), 3);
    check("t3_drop_swap", 32'(b2.drop_a), 0);
    b2.arr_a = 1'b0;
    step();
    check("t3_qa_timer0", 32'(b2.qa), 3);
    b2.La = YELLOW;
    step();
    check("t3_qa_yellow", 32'(b2.qa), 2);
    b2.La = RED;
    step();
    check("t3_err2", 32'(b2.err), 0);

    // 4. Skipped yellow
    do_reset();
    b1.La = GREEN; b1.Lb = RED;
    step();
    check("t4_err_pre", 32'(b1.err), 0);
    b1.La = RED;
    step();
    check("t4_code", 32'(b1.err_code), 3'b010);
    check("t4_err", 32'(b1.err), 1);
    b1.La = GREEN;
    step();
    check("t4_sticky", 32'(b1.err_code), 3'b010);

    // 5. Conflict, then illegal code
    do_reset();
    b1.La = RED; b1.Lb = GREEN;
    step();
    check("t5_clean", 32'(b1.err_code), 0);
    b1.La = GREEN; b1.Lb = YELLOW;
    step();
    check("t5_conflict", 32'(b1.err_code), 3'b100);
    b1.La = ILLEGAL;
    step();
    check("t5_code11", 32'(b1.err_code), 3'b101);

    // 6. Asynchronous reset mid-release
    b1.La = RED; b1.Lb = RED;
    do_reset();
    b1.arr_a = 1'b1;
    for (int i = 0; i < 5; i++) step();
    b1.arr_a = 1'b0;
    check("t6_qa5", 32'(b1.qa), 5);
    b1.La = GREEN;
    step();
    b1.Lb = ILLEGAL;
    step();
    check("t6_qa4", 32'(b1.qa), 4);
    check("t6_err_set", 32'(b1.err), 1);
    #3 reset = 1'b1;
    #1;
    check("t6_qa_async", 32'(b1.qa), 0);
    check("t6_Ta_async", 32'(b1.Ta), 0);
    check("t6_err_async", 32'(b1.err), 0);
    b1.arr_a = 1'b1;
    b1.La = RED; b1.Lb = RED;
    step();
    check("t6_arr_ignored", 32'(b1.qa), 0);
    b1.arr_a = 1'b0;
    reset = 1'b0;
    step();

    // 7. Street B queue and release
    b1.arr_b = 1'b1;
    step(); step();
    b1.arr_b = 1'b0;
    check("t7_qb", 32'(b1.qb), 2);
    check("t7_Tb", 32'(b1.Tb), 1);
    b1.Lb = GREEN;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t7_qb_%0d", i), 32'(b1.qb), 32'(exp_b[i]));
    end
    check("t7_Tb_low", 32'(b1.Tb), 0);
    check("t7_qa", 32'(b1.qa), 0);
    check("t7_err", 32'(b1.err), 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
